div_clk_select: RTL and testbench

- Downstream consumer of the 4-bit clock divider. It takes the divby2/divby4/divby8/divby16 waveforms and produces one selected, registered divided waveform plus a 1-cycle rising-edge tick.
- The selection can be changed at run time through a req/ack handshake. The switch is glitch-free: no truncated high phase ever appears on clk_out.
- Sits between the divider and any logic that needs a software-selectable slow strobe.

---
 rtl/div_clk_select_pkg.sv | 30 +++
 rtl/div_clk_select_if.sv | 37 +++
 rtl/div_clk_select_rise_pulse.sv | 42 ++++
 rtl/div_clk_select.sv | 138 +++++++++++++
 tb/tb_div_clk_select.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_clk_select_pkg.sv
// rtl/div_clk_select_pkg.sv - shared types and constants for the divided-clock selector
//
// Holds the switch FSM state encoding, the selection codes that name each
// divider tap, and a small helper that picks one tap out of the divider bus.

package div_clk_select_pkg;

    // Selection code: index into the divider tap bus {divby16, divby8, divby4, divby2}.
    typedef logic [1:0] sel_t;

    localparam sel_t SEL_DIV2  = 2'd0;
    localparam sel_t SEL_DIV4  = 2'd1;
    localparam sel_t SEL_DIV8  = 2'd2;
    localparam sel_t SEL_DIV16 = 2'd3;

    // IDLE         : clk_out follows the current tap, requests accepted.
    // WAIT_OLD_LOW : request latched, waiting for the current tap to go low.
    // WAIT_NEW_LOW : clk_out gated low, waiting for the pending tap to go low.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_OLD_LOW = 2'd1,
        WAIT_NEW_LOW = 2'd2
    } state_t;

    // Return the divider tap addressed by a selection code.
    function automatic logic pick_tap(input logic [3:0] taps, input sel_t sel);
        return taps[sel];
    endfunction

endpackage

// File: rtl/div_clk_select_if.sv
// rtl/div_clk_select_if.sv - selection request/acknowledge bus for the divided-clock selector
//
// Signals:
//   sel_req  requester -> selector  1-cycle request to change selection
//   sel_in   requester -> selector  requested selection, sampled with sel_req
//   sel_ack  selector -> requester  1-cycle pulse when a request completes
//   busy     selector -> requester  switch in progress; requests are dropped
//   sel_cur  selector -> requester  selection currently driving clk_out
//
// Modports: master = requester side, slave = selector side.

interface div_clk_select_if;
    import div_clk_select_pkg::*;

    logic sel_req;
    sel_t sel_in;
    logic sel_ack;
    logic busy;
    sel_t sel_cur;

    modport master (
        output sel_req,
        output sel_in,
        input  sel_ack,
        input  busy,
        input  sel_cur
    );

    modport slave (
        input  sel_req,
        input  sel_in,
        output sel_ack,
        output busy,
        output sel_cur
    );

endinterface

// File: rtl/div_clk_select_rise_pulse.sv
// rtl/div_clk_select_rise_pulse.sv - registered rising-edge detector with enable
//
// Produces a registered pulse that is high in the first cycle a registered
// signal reads 1. The caller supplies both the signal's next value (sig_d)
// and its current registered value (sig_q), so the pulse lines up with the
// first high cycle of that register rather than trailing it by one.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   en     in   enable; when 0 the pulse register is forced to 0
//   sig_d  in   next value of the watched register
//   sig_q  in   current value of the watched register
//   pulse  out  1-cycle rising-edge pulse

module div_clk_select_rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sig_d,
    input  logic sig_q,
    output logic pulse
);

    logic pulse_d;
    logic pulse_q;

    always_comb begin
        pulse_d = en & sig_d & ~sig_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/div_clk_select.sv
// rtl/div_clk_select.sv - glitch-free run-time selectable divided clock strobe
//
// Picks one of the divider taps (div2/div4/div8/div16), registers it onto
// clk_out and emits a 1-cycle tick in clk_out's first high cycle. The tap can
// be changed through a req/ack handshake; the switch waits for the old tap to
// go low, then holds clk_out low until the new tap is also low, so no high
// phase on clk_out is ever shortened (low phases may stretch instead).
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   en        in   global enable; 0 freezes state, forces tick/sel_ack low
//   divby2    in   divider bit 0
//   divby4    in   divider bit 1
//   divby8    in   divider bit 2
//   divby16   in   divider bit 3
//   clk_out   out  registered selected waveform
//   tick      out  1-cycle pulse in the first cycle clk_out reads 1
//   sel_bus   slave side of the selection handshake (sel_req, sel_in,
//             sel_ack, busy, sel_cur)

module div_clk_select
    import div_clk_select_pkg::*;
#(
    parameter sel_t DEFAULT_SEL = SEL_DIV2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   divby2,
    input  logic                   divby4,
    input  logic                   divby8,
    input  logic                   divby16,
    div_clk_select_if.slave        sel_bus,
    output logic                   clk_out,
    output logic                   tick
);

    state_t     state_q,   state_d;
    sel_t       sel_cur_q, sel_cur_d;
    sel_t       sel_pend_q, sel_pend_d;
    logic       clk_out_q, clk_out_d;
    logic       sel_ack_q, sel_ack_d;

    logic [3:0] taps;
    logic       src_cur;
    logic       src_pend;
    logic       gate;

    // Tap mux: both the live selection and the pending one are looked at,
    // the latter only to find the moment the new tap is low.
    always_comb begin
        taps     = {divby16, divby8, divby4, divby2};
        src_cur  = pick_tap(taps, sel_cur_q);
        src_pend = pick_tap(taps, sel_pend_q);
        gate     = (state_q == WAIT_NEW_LOW);
    end

    always_comb begin
        state_d    = state_q;
        sel_cur_d  = sel_cur_q;
        sel_pend_d = sel_pend_q;
        clk_out_d  = clk_out_q;
        sel_ack_d  = 1'b0;

        if (en) begin
            // While gated the output is pinned low; the old tap already
            // delivered a low into clk_out on the way into WAIT_NEW_LOW.
            clk_out_d = gate ? 1'b0 : src_cur;

            unique case (state_q)
                IDLE: begin
                    if (sel_bus.sel_req) begin
                        if (sel_bus.sel_in == sel_cur_q) begin
                            sel_ack_d = 1'b1;
                        end else begin
                            sel_pend_d = sel_bus.sel_in;
                            state_d    = WAIT_OLD_LOW;
                        end
                    end
                end

                WAIT_OLD_LOW: begin
                    // clk_out registers this same low sample, so it falls
                    // at the natural end of the old high phase.
                    if (!src_cur) begin
                        state_d = WAIT_NEW_LOW;
                    end
                end

                WAIT_NEW_LOW: begin
                    // Hand over only while the new tap is low, so the first
                    // high cycle clk_out shows is the start of a full phase.
                    if (!src_pend) begin
                        sel_cur_d = sel_pend_q;
                        sel_ack_d = 1'b1;
                        state_d   = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_cur_q  <= DEFAULT_SEL;
            sel_pend_q <= DEFAULT_SEL;
            clk_out_q  <= 1'b0;
            sel_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_cur_q  <= sel_cur_d;
            sel_pend_q <= sel_pend_d;
            clk_out_q  <= clk_out_d;
            sel_ack_q  <= sel_ack_d;
        end
    end

    div_clk_select_rise_pulse u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .sig_d (clk_out_d),
        .sig_q (clk_out_q),
        .pulse (tick)
    );

    assign clk_out         = clk_out_q;
    assign sel_bus.sel_ack = sel_ack_q;
    assign sel_bus.busy    = (state_q != IDLE);
    assign sel_bus.sel_cur = sel_cur_q;

endmodule

// File: tb/tb_div_clk_select.sv
// tb/tb_div_clk_select.sv - scoreboard bench for the divided-clock selector

module tb_div_clk_select;
    import div_clk_select_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [3:0] cnt = 4'd0;
    logic       clk_out;
    logic       tick;

    div_clk_select_if sel_bus();

    div_clk_select #(.DEFAULT_SEL(SEL_DIV2)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .divby2  (cnt[0]),
        .divby4  (cnt[1]),
        .divby8  (cnt[2]),
        .divby16 (cnt[3]),
        .sel_bus (sel_bus),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    // Free-running 4-bit divider feeding the taps.
    always @(posedge clk) cnt <= cnt + 4'd1;

    typedef struct {
        sel_t       sel;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic switching = 1'b1;
    sel_t trk_sel   = SEL_DIV2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // Pops an expectation on every sel_ack, tracks clk_out/tick against the
    // selected tap outside switch windows, and checks every high run length.
    task automatic monitor();
        exp_t       e;
        logic       clk_prev = 1'b0;
        int         run  = 0;
        logic       skip = 1'b0;
        logic [3:0] pc;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                run      = 0;
                skip     = 1'b0;
                clk_prev = 1'b0;
                trk_sel  = SEL_DIV2;
            end else begin
                if (sel_bus.sel_ack) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", 32'(sel_bus.sel_ack), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_sel", 32'(sel_bus.sel_cur), 32'(e.sel));
                        check("ack_cnt", 32'(cnt), 32'(e.cnt));
                        trk_sel = e.sel;
                    end
                end
                if (!en) skip = 1'b1;
                if (!switching && en) begin
                    pc = cnt - 4'd1;
                    check("clk_out_track", 32'(clk_out), 32'(pc[trk_sel]));
                    check("tick_track", 32'(tick), 32'(clk_out & ~clk_prev));
                end
                if (clk_out) begin
                    run++;
                end else begin
                    if (run > 0) begin
                        if (!skip) check("high_run", run, 32'(1 << trk_sel));
                        skip = 1'b0;
                    end
                    run = 0;
                end
                clk_prev = clk_out;
            end
        end
    endtask

    task automatic wait_cnt(input logic [3:0] v);
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (cnt == v) found = 1'b1;
        end
        if (!found) check("wait_cnt_timeout", 32'(cnt), 32'(v));
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("ack_timeout", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic request(input sel_t s, input logic expect_ack, input sel_t esel, input logic [3:0] ecnt);
        exp_t e;
        sel_bus.sel_in  = s;
        sel_bus.sel_req = 1'b1;
        if (expect_ack) begin
            e.sel = esel;
            e.cnt = ecnt;
            exp_q.push_back(e);
        end
        @(negedge clk);
        sel_bus.sel_req = 1'b0;
    endtask

    initial begin
        sel_bus.sel_req = 1'b0;
        sel_bus.sel_in  = SEL_DIV2;
        fork
            monitor();
        join_none

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_busy", 32'(sel_bus.busy), 32'd0);
        check("rst_sel_ack", 32'(sel_bus.sel_ack), 32'd0);
        check("rst_sel_cur", 32'(sel_bus.sel_cur), 32'(SEL_DIV2));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        switching = 1'b0;
        repeat (16) @(negedge clk);

        // 0 -> 3 requested at count 5: ack in the count-8 cycle.
        wait_cnt(4'd5);
        switching = 1'b1;
        request(SEL_DIV16, 1'b1, SEL_DIV16, 4'd8);
        wait_empty();
        switching = 1'b0;

        // 3 -> 0 requested at count 9: busy across the wrap, ack at count 3.
        wait_cnt(4'd9);
        switching = 1'b1;
        request(SEL_DIV2, 1'b1, SEL_DIV2, 4'd3);
        wait_cnt(4'd0);
        check("busy_at_wrap", 32'(sel_bus.busy), 32'd1);
        wait_empty();
        switching = 1'b0;

        // Same selection: ack one cycle later, no busy, clk_out keeps tracking.
        wait_cnt(4'd10);
        request(SEL_DIV2, 1'b1, SEL_DIV2, 4'd11);
        check("busy_same_sel", 32'(sel_bus.busy), 32'd0);
        wait_empty();

        // 0 -> 2 with a second request while busy: only the first is acked.
        wait_cnt(4'd12);
        switching = 1'b1;
        request(SEL_DIV8, 1'b1, SEL_DIV8, 4'd1);
        wait_cnt(4'd14);
        check("busy_second_req", 32'(sel_bus.busy), 32'd1);
        request(SEL_DIV4, 1'b0, SEL_DIV4, 4'd0);
        wait_empty();
        switching = 1'b0;

        // 2 -> 3 frozen by en=0 for 10 cycles while waiting for the old tap.
        wait_cnt(4'd4);
        switching = 1'b1;
        request(SEL_DIV16, 1'b1, SEL_DIV16, 4'd2);
        wait_cnt(4'd6);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("freeze_clk_out", 32'(clk_out), 32'd1);
            check("freeze_busy", 32'(sel_bus.busy), 32'd1);
            check("freeze_tick", 32'(tick), 32'd0);
        end
        en = 1'b1;
        wait_empty();
        switching = 1'b0;

        // 3 -> 2 interrupted by reset in WAIT_NEW_LOW: no ack may follow.
        wait_cnt(4'd3);
        switching = 1'b1;
        request(SEL_DIV8, 1'b0, SEL_DIV8, 4'd0);
        @(negedge clk);
        check("busy_before_rst", 32'(sel_bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_clk_out", 32'(clk_out), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_busy", 32'(sel_bus.busy), 32'd0);
        check("arst_sel_ack", 32'(sel_bus.sel_ack), 32'd0);
        check("arst_sel_cur", 32'(sel_bus.sel_cur), 32'(SEL_DIV2));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (24) @(negedge clk);
        switching = 1'b0;
        repeat (16) @(negedge clk);
        check("sel_cur_after_rst", 32'(sel_bus.sel_cur), 32'(SEL_DIV2));
        check("sb_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
